serial_alu_gen: RTL

SERIAL_ALU_GEN -- requirements
Module: serial_alu_gen

---
 rtl/serial_alu_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_alu_gen.sv
// serial_alu_gen
// Bit-serial adder / comparator. Two operands arrive LSB first on line1/line2,
// one bit per in_valid cycle. The mode sampled on bit 0 of a word selects add
// or compare for the whole word.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - synchronous, active-high
//   line1      - operand A serial bit, LSB first
//   line2      - operand B serial bit, LSB first
//   in_valid   - line1/line2 valid this cycle; low stalls the block
//   mode       - 0 = add, 1 = compare (sampled on bit 0 only)
//   outp       - registered serial result bit
//   overflw    - one-cycle pulse on the last bit of an add word that overflowed
//   word_done  - one-cycle pulse when the last bit of a word is consumed
//   cmp_lt/eq/gt - relation from the last completed compare word
//   bit_cnt    - index of the next expected bit
module serial_alu_gen #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0,
  localparam int CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          line1,
  input  logic          line2,
  input  logic          in_valid,
  input  logic          mode,
  output logic          outp,
  output logic          overflw,
  output logic          word_done,
  output logic          cmp_lt,
  output logic          cmp_eq,
  output logic          cmp_gt,
  output logic [CW-1:0] bit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_CMP} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  rel_t   relation;
  logic   carry;

  logic first_bit;
  logic is_cmp;
  logic last_bit;
  logic carry_in;
  logic carry_out;
  logic sum_bit;
  rel_t rel_in;
  rel_t rel_next;

  // The FSM only sits in S_IDLE while waiting for bit 0, so the idle state
  // doubles as the "first bit" marker. The word's operation comes from the
  // live mode input on bit 0 and from the latched state afterwards, which
  // makes mid-word mode changes invisible.
  always_comb begin
    first_bit = (state == S_IDLE);
    is_cmp    = first_bit ? mode : (state == S_CMP);
    last_bit  = (bit_cnt == LAST);
    carry_in  = first_bit ? 1'b0 : carry;
    sum_bit   = line1 ^ line2 ^ carry_in;
    carry_out = (line1 & line2) | (line1 & carry_in) | (line2 & carry_in);
    rel_in    = first_bit ? REL_EQ : relation;
    rel_next  = rel_in;
    // Higher bits override lower ones, so the latest differing bit wins.
    if (line1 != line2) begin
      rel_next = line1 ? REL_GT : REL_LT;
    end
    // A differing sign bit flips the sense in two's complement: the operand
    // with the MSB set is the negative (smaller) one.
    if (SIGNED && last_bit && (line1 != line2)) begin
      rel_next = line1 ? REL_LT : REL_GT;
    end
  end

  // Single registered FSM: consumes one bit per valid cycle, produces the
  // result bit and the end-of-word pulses, and returns to S_IDLE after the
  // last bit so the next valid cycle immediately starts a new word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      carry     <= 1'b0;
      relation  <= REL_EQ;
      outp      <= 1'b0;
      overflw   <= 1'b0;
      word_done <= 1'b0;
      cmp_lt    <= 1'b0;
      cmp_eq    <= 1'b0;
      cmp_gt    <= 1'b0;
    end else begin
      overflw   <= 1'b0;
      word_done <= 1'b0;
      if (in_valid) begin
        bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
        word_done <= last_bit;
        if (last_bit) begin
          state <= S_IDLE;
        end else begin
          state <= is_cmp ? S_CMP : S_ADD;
        end
        if (!is_cmp) begin
          outp  <= sum_bit;
          carry <= carry_out;
          if (last_bit) begin
            overflw <= SIGNED ? (carry_in ^ carry_out) : carry_out;
          end
        end else begin
          outp     <= ~(line1 ^ line2);
          relation <= rel_next;
          if (last_bit) begin
            cmp_lt <= (rel_next == REL_LT);
            cmp_eq <= (rel_next == REL_EQ);
            cmp_gt <= (rel_next == REL_GT);
          end
        end
      end
    end
  end

endmodule
